// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module  : button_pkg
// Brief   : Shared state encoding and ms-to-cycles helper for button_event.
// Revision: 1.0 - initial release
// ============================================================================
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    localparam int unsigned c_MS_PER_S = 1000;

    // Cycles = (Hz / 1000) * ms, kept in 32-bit unsigned arithmetic.
    function automatic logic [31:0] ms_to_cycles(input int unsigned freq_hz,
                                                 input int unsigned ms);
        return 32'((freq_hz / c_MS_PER_S) * ms);
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_if.sv
`default_nettype none
// ============================================================================
// Module  : button_event_if
// Brief   : Button level input and event/pulse outputs of button_event.
// Revision: 1.0 - initial release
// ============================================================================
interface button_event_if;
    logic level_i;
    logic press_o;
    logic click_o;
    logic long_o;
    logic release_o;
    logic repeat_o;
    logic held_o;

    modport slave (
        input  level_i,
        output press_o, click_o, long_o, release_o, repeat_o, held_o
    );

    modport master (
        output level_i,
        input  press_o, click_o, long_o, release_o, repeat_o, held_o
    );
endinterface
`default_nettype wire

// File: rtl/tick_timer.sv
`default_nettype none
// ============================================================================
// Module  : tick_timer
// Brief   : Enabled cycle counter; flags the last cycle of each LIMIT period.
// Revision: 1.0 - initial release
// ============================================================================
module tick_timer (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_en,
    input  wire logic [31:0] i_limit,
    output logic             o_tick
);

    logic [31:0] r_count;

    assign o_tick = i_en && (r_count == (i_limit - 32'd1));

    // Held at zero while disabled so each enable window starts a fresh period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 32'd0;
        end else if (!i_en || o_tick) begin
            r_count <= 32'd0;
        end else begin
            r_count <= r_count + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
// Module  : button_event
// Brief   : Press / click / long-press / release / auto-repeat event decoder.
//           Auto-repeat is built only when BUTTON_AUTO_REPEAT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module button_event
    import button_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ    = 50000000,
    parameter int unsigned LONG_PRESS_MS = 1000,
    parameter int unsigned REPEAT_MS     = 200
) (
    input  wire logic     clk,
    input  wire logic     rst,
    button_event_if.slave bus
);

    localparam logic [31:0] c_LONG_LIM = ms_to_cycles(CLOCK_FREQ, LONG_PRESS_MS);

    state_t r_state;
    logic   r_press;
    logic   r_click;
    logic   r_long;
    logic   r_release;
    logic   r_held;
    logic   w_long_en;
    logic   w_long_tick;

    assign w_long_en = (r_state == ST_PRESSED);

    tick_timer u_long_timer (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_long_en),
        .i_limit (c_LONG_LIM),
        .o_tick  (w_long_tick)
    );

    assign bus.press_o   = r_press;
    assign bus.click_o   = r_click;
    assign bus.long_o    = r_long;
    assign bus.release_o = r_release;
    assign bus.held_o    = r_held;

    // A release sampled on the expiry cycle wins over the long-press transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_press   <= 1'b0;
            r_click   <= 1'b0;
            r_long    <= 1'b0;
            r_release <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_click   <= 1'b0;
            r_long    <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.level_i) begin
                        r_state <= ST_PRESSED;
                        r_press <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!bus.level_i) begin
                        r_state   <= ST_IDLE;
                        r_click   <= 1'b1;
                        r_release <= 1'b1;
                    end else if (w_long_tick) begin
                        r_state <= ST_HELD;
                        r_long  <= 1'b1;
                        r_held  <= 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!bus.level_i) begin
                        r_state   <= ST_IDLE;
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [31:0] c_REP_LIM = ms_to_cycles(CLOCK_FREQ, REPEAT_MS);

    logic w_rep_en;
    logic w_rep_tick;
    logic r_repeat;

    assign w_rep_en = (r_state == ST_HELD);

    tick_timer u_rep_timer (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_rep_en),
        .i_limit (c_REP_LIM),
        .o_tick  (w_rep_tick)
    );

    // Suppressed on the release cycle so no repeat follows the release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= w_rep_tick && bus.level_i;
        end
    end

    assign bus.repeat_o = r_repeat;
`else
    assign bus.repeat_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_event.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_event
// Brief   : Self-checking bench for button_event against an event-time model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_event;

    localparam int unsigned c_CLOCK_FREQ = 10000;
    localparam int unsigned c_LONG_MS    = 5;
    localparam int unsigned c_REP_MS     = 2;
    localparam int          c_LONG       = (c_CLOCK_FREQ / 1000) * c_LONG_MS;
    localparam int          c_REP        = (c_CLOCK_FREQ / 1000) * c_REP_MS;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit          c_REP_EN     = 1'b1;
`else
    localparam bit          c_REP_EN     = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    button_event_if bus ();

    button_event #(
        .CLOCK_FREQ    (c_CLOCK_FREQ),
        .LONG_PRESS_MS (c_LONG_MS),
        .REPEAT_MS     (c_REP_MS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          edge_idx = 0;
    int          press_edge = -1;
    logic [5:0]  exp_v = 6'b0;

    // {press, click, long, release, repeat, held}
    function automatic logic [5:0] obs();
        return {bus.press_o, bus.click_o, bus.long_o, bus.release_o, bus.repeat_o, bus.held_o};
    endfunction

    // Drive one level for one clock edge and derive the expected outputs from
    // the time elapsed since the accepted press.
    task automatic step(input logic lvl);
        logic p, c, l, r, rp, h;
        int   d;
        p = 0; c = 0; l = 0; r = 0; rp = 0; h = 0;
        bus.level_i = lvl;
        @(posedge clk);
        edge_idx++;
        if (press_edge < 0) begin
            if (lvl) begin
                p = 1;
                press_edge = edge_idx;
            end
        end else begin
            d = edge_idx - press_edge;
            if (!lvl) begin
                r = 1;
                c = (d <= c_LONG);
                press_edge = -1;
            end else begin
                l  = (d == c_LONG);
                rp = c_REP_EN && (d > c_LONG) && (((d - c_LONG) % c_REP) == 0);
                h  = (d >= c_LONG);
            end
        end
        exp_v = {p, c, l, r, rp, h};
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.level_i = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %b want %b", obs(), 6'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs() !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_clocked: got %b want %b", obs(), 6'b0);
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            n_checks++;
            if (obs() !== exp_v) begin
                n_fail++;
                $display("FAIL reset_idle edge %0d: got %b want %b", edge_idx, obs(), exp_v);
            end
        end
    endtask

    task automatic test_click();
        int presses = 0, clicks = 0, longs = 0;
        for (int i = 0; i < 14; i++) begin
            step(i < 10);
            n_checks++;
            if (obs() !== exp_v) begin
                n_fail++;
                $display("FAIL click_seq edge %0d: got %b want %b", edge_idx, obs(), exp_v);
            end
            presses += int'(bus.press_o);
            clicks  += int'(bus.click_o && bus.release_o);
            longs   += int'(bus.long_o);
        end
        n_checks++;
        if (presses != 1 || clicks != 1 || longs != 0) begin
            n_fail++;
            $display("FAIL click_counts: got press=%0d click+rel=%0d long=%0d want 1 1 0",
                     presses, clicks, longs);
        end
    endtask

    task automatic test_long();
        int press_at = -1, long_at = -1, clicks = 0;
        for (int i = 0; i < 81; i++) begin
            step(i < 80);
            n_checks++;
            if (obs() !== exp_v) begin
                n_fail++;
                $display("FAIL long_seq edge %0d: got %b want %b", edge_idx, obs(), exp_v);
            end
            if (bus.press_o) press_at = edge_idx;
            if (bus.long_o)  long_at  = edge_idx;
            clicks += int'(bus.click_o);
        end
        n_checks++;
        if (long_at - press_at != c_LONG || clicks != 0 || bus.release_o !== 1'b1 || bus.held_o !== 1'b0) begin
            n_fail++;
            $display("FAIL long_timing: got delay=%0d clicks=%0d rel=%b held=%b want %0d 0 1 0",
                     long_at - press_at, clicks, bus.release_o, bus.held_o, c_LONG);
        end
        step(1'b0);
    endtask

    task automatic test_boundary();
        int longs = 0, helds = 0;
        for (int i = 0; i < c_LONG + 1; i++) begin
            step(i < c_LONG);
            n_checks++;
            if (obs() !== exp_v) begin
                n_fail++;
                $display("FAIL boundary_seq edge %0d: got %b want %b", edge_idx, obs(), exp_v);
            end
            longs += int'(bus.long_o);
            helds += int'(bus.held_o);
        end
        n_checks++;
        if (bus.click_o !== 1'b1 || bus.release_o !== 1'b1 || longs != 0 || helds != 0) begin
            n_fail++;
            $display("FAIL boundary_release: got click=%b rel=%b longs=%0d helds=%0d want 1 1 0 0",
                     bus.click_o, bus.release_o, longs, helds);
        end
        // One cycle later: long press already taken, release gives no click.
        for (int i = 0; i < c_LONG + 3; i++) begin
            step(i < c_LONG + 1);
            n_checks++;
            if (obs() !== exp_v) begin
                n_fail++;
                $display("FAIL boundary_plus1 edge %0d: got %b want %b", edge_idx, obs(), exp_v);
            end
        end
    endtask

    task automatic test_repeat();
        int long_at = -1;
        int offs[$];
        for (int i = 0; i < 133; i++) begin
            step(i < 130);
            n_checks++;
            if (obs() !== exp_v) begin
                n_fail++;
                $display("FAIL repeat_seq edge %0d: got %b want %b", edge_idx, obs(), exp_v);
            end
            if (bus.long_o) long_at = edge_idx;
            if (bus.repeat_o) offs.push_back(edge_idx - long_at);
        end
        n_checks++;
        if (c_REP_EN) begin
            if (offs.size() != 3 || offs[0] != 20 || offs[1] != 40 || offs[2] != 60) begin
                n_fail++;
                $display("FAIL repeat_offsets: got %0d pulses want 20 40 60 after long", offs.size());
            end
        end else if (offs.size() != 0) begin
            n_fail++;
            $display("FAIL repeat_disabled: got %0d pulses want 0", offs.size());
        end
    endtask

    task automatic test_reset_mid_held();
        int presses = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1);
            n_checks++;
            if (obs() !== exp_v) begin
                n_fail++;
                $display("FAIL midheld_seq edge %0d: got %b want %b", edge_idx, obs(), exp_v);
            end
        end
        #2 rst = 1'b1;
        press_edge = -1;
        #1;
        n_checks++;
        if (obs() !== 6'b0) begin
            n_fail++;
            $display("FAIL midheld_async: got %b want %b", obs(), 6'b0);
        end
        @(posedge clk);
        edge_idx++;
        #1;
        n_checks++;
        if (obs() !== 6'b0) begin
            n_fail++;
            $display("FAIL midheld_no_release: got %b want %b", obs(), 6'b0);
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(i < 4);
            n_checks++;
            if (obs() !== exp_v) begin
                n_fail++;
                $display("FAIL midheld_after edge %0d: got %b want %b", edge_idx, obs(), exp_v);
            end
            if (i == 0 && bus.press_o !== 1'b1) begin
                n_fail++;
                $display("FAIL midheld_repress: got press=%b want 1", bus.press_o);
            end
            presses += int'(bus.press_o);
        end
        n_checks++;
        if (presses != 1) begin
            n_fail++;
            $display("FAIL midheld_press_count: got %0d want 1", presses);
        end
    endtask

    task automatic test_back_to_back();
        int rel_at = -1, press_at = -1;
        logic pat[$] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 0, 0};
        foreach (pat[i]) begin
            step(pat[i]);
            n_checks++;
            if (obs() !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_seq edge %0d: got %b want %b", edge_idx, obs(), exp_v);
            end
            if (bus.release_o && rel_at < 0) rel_at = edge_idx;
            if (bus.press_o && rel_at >= 0 && press_at < 0) press_at = edge_idx;
        end
        n_checks++;
        if (rel_at < 0 || press_at != rel_at + 1) begin
            n_fail++;
            $display("FAIL b2b_consecutive: got release@%0d press@%0d want press one cycle after release",
                     rel_at, press_at);
        end
    endtask

    task automatic test_random();
        int len, gap, pick;
        for (int k = 0; k < 24; k++) begin
            pick = int'($urandom_range(0, 5));
            case (pick)
                0:       len = c_LONG - 1;
                1:       len = c_LONG;
                2:       len = c_LONG + 1;
                3:       len = int'($urandom_range(c_LONG + 2, c_LONG + 3 * c_REP + 5));
                default: len = int'($urandom_range(1, c_LONG - 2));
            endcase
            gap = int'($urandom_range(1, 4));
            for (int i = 0; i < len + gap; i++) begin
                step(i < len);
                n_checks++;
                if (obs() !== exp_v) begin
                    n_fail++;
                    $display("FAIL random_seq iter %0d edge %0d: got %b want %b", k, edge_idx, obs(), exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_click();
        test_long();
        test_boundary();
        test_repeat();
        test_reset_mid_held();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
